// File: rtl/trap_ctrl_pkg.sv
// Shared machine-mode CSR types, ISA constants and the trap sequencer state encoding.
// Also holds the mstatus/mtvec update rules used by the trap sequencer.
package trap_ctrl_pkg;

    typedef logic [31:0] word_t;
    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t ISA_CSR_ADDR_MSTATUS = 12'h300;
    localparam csr_addr_t ISA_CSR_ADDR_MTVEC   = 12'h305;
    localparam csr_addr_t ISA_CSR_ADDR_MEPC    = 12'h341;
    localparam csr_addr_t ISA_CSR_ADDR_MCAUSE  = 12'h342;

    localparam int ISA_MSTATUS_MIE    = 3;
    localparam int ISA_MSTATUS_MPIE   = 7;
    localparam int ISA_MSTATUS_MPP_LO = 11;

    localparam word_t ISA_MCAUSE_MEI = 32'h8000000B;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        R_MTVEC,
        M_STATUS,
        M_EPC
    } trap_state_t;

    // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous privilege.
    function automatic word_t trap_mstatus(input word_t ms);
        word_t r;
        r = ms;
        r[ISA_MSTATUS_MPIE] = ms[ISA_MSTATUS_MIE];
        r[ISA_MSTATUS_MIE] = 1'b0;
        r[ISA_MSTATUS_MPP_LO +: 2] = 2'b11;
        return r;
    endfunction

    function automatic word_t mret_mstatus(input word_t ms);
        word_t r;
        r = ms;
        r[ISA_MSTATUS_MIE] = ms[ISA_MSTATUS_MPIE];
        r[ISA_MSTATUS_MPIE] = 1'b1;
        r[ISA_MSTATUS_MPP_LO +: 2] = 2'b11;
        return r;
    endfunction

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    function automatic word_t mtvec_target(input word_t mtvec, input word_t cause);
        word_t base;
        base = {mtvec[31:2], 2'b00};
        if (mtvec[1:0] == 2'b01 && cause[31])
            return base + (word_t'(cause[30:0]) << 2);
        return base;
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: passes Zicsr traffic through in IDLE and serialises
// trap-entry / mret CSR updates through the single csr_file port, then redirects the PC.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      exc_valid,
    input  word_t     exc_cause,
    input  word_t     exc_pc,
    input  logic      mret_valid,
    input  logic      irq_ext,
    input  word_t     irq_pc,
    input  logic      core_csr_we,
    input  csr_addr_t core_csr_addr,
    input  word_t     core_csr_wdata,
    output word_t     core_csr_rdata,
    output logic      csr_write_en,
    output csr_addr_t csr_addr,
    output word_t     csr_wdata,
    input  word_t     csr_rdata,
    input  word_t     mstatus,
    output logic      busy,
    output logic      redirect_valid,
    output word_t     redirect_pc
);

    trap_state_t r_state;
    word_t       r_pc;
    word_t       r_cause;
    word_t       r_redirect_pc;
    logic        r_redirect_valid;

    logic w_idle;
    logic w_take_exc;
    logic w_take_mret;
    logic w_take_irq;
    logic w_accept;

    assign w_idle      = (r_state == IDLE);
    assign w_take_exc  = w_idle && exc_valid;
    assign w_take_mret = w_idle && !exc_valid && mret_valid;
    assign w_take_irq  = w_idle && !exc_valid && !mret_valid && irq_ext && mstatus[ISA_MSTATUS_MIE];
    assign w_accept    = w_take_exc || w_take_mret || w_take_irq;

    assign busy           = !w_idle;
    assign core_csr_rdata = csr_rdata;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

    always_comb begin
        csr_write_en = 1'b0;
        csr_addr     = core_csr_addr;
        csr_wdata    = core_csr_wdata;
        case (r_state)
            // A core write colliding with an accepted trap/mret would race the sequence; drop it.
            IDLE: csr_write_en = core_csr_we && !w_accept && rst_n;
            W_MEPC: begin
                csr_write_en = 1'b1;
                csr_addr     = ISA_CSR_ADDR_MEPC;
                csr_wdata    = r_pc;
            end
            W_MCAUSE: begin
                csr_write_en = 1'b1;
                csr_addr     = ISA_CSR_ADDR_MCAUSE;
                csr_wdata    = r_cause;
            end
            W_MSTATUS: begin
                csr_write_en = 1'b1;
                csr_addr     = ISA_CSR_ADDR_MSTATUS;
                csr_wdata    = trap_mstatus(mstatus);
            end
            R_MTVEC: begin
                csr_addr  = ISA_CSR_ADDR_MTVEC;
                csr_wdata = '0;
            end
            M_STATUS: begin
                csr_write_en = 1'b1;
                csr_addr     = ISA_CSR_ADDR_MSTATUS;
                csr_wdata    = mret_mstatus(mstatus);
            end
            M_EPC: begin
                csr_addr  = ISA_CSR_ADDR_MEPC;
                csr_wdata = '0;
            end
            default: csr_write_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_pc             <= '0;
            r_cause          <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_take_exc) begin
                        r_pc    <= exc_pc;
                        r_cause <= exc_cause;
                        r_state <= W_MEPC;
                    end else if (w_take_mret) begin
                        r_state <= M_STATUS;
                    end else if (w_take_irq) begin
                        r_pc    <= irq_pc;
                        r_cause <= ISA_MCAUSE_MEI;
                        r_state <= W_MEPC;
                    end
                end
                W_MEPC:    r_state <= W_MCAUSE;
                W_MCAUSE:  r_state <= W_MSTATUS;
                W_MSTATUS: r_state <= R_MTVEC;
                R_MTVEC: begin
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= mtvec_target(csr_rdata, r_cause);
                    r_state          <= IDLE;
                end
                M_STATUS:  r_state <= M_EPC;
                M_EPC: begin
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= {csr_rdata[31:2], 2'b00};
                    r_state          <= IDLE;
                end
                default:   r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: behavioural csr_file, transaction-level reference
// model of trap entry / mret, directed scenarios followed by randomized requests.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      exc_valid = 1'b0;
    word_t     exc_cause = '0;
    word_t     exc_pc = '0;
    logic      mret_valid = 1'b0;
    logic      irq_ext = 1'b0;
    word_t     irq_pc = '0;
    logic      core_csr_we = 1'b0;
    csr_addr_t core_csr_addr = '0;
    word_t     core_csr_wdata = '0;
    word_t     core_csr_rdata;
    logic      csr_write_en;
    csr_addr_t csr_addr;
    word_t     csr_wdata;
    word_t     csr_rdata;
    word_t     mstatus;
    logic      busy;
    logic      redirect_valid;
    word_t     redirect_pc;

    trap_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .mret_valid     (mret_valid),
        .irq_ext        (irq_ext),
        .irq_pc         (irq_pc),
        .core_csr_we    (core_csr_we),
        .core_csr_addr  (core_csr_addr),
        .core_csr_wdata (core_csr_wdata),
        .core_csr_rdata (core_csr_rdata),
        .csr_write_en   (csr_write_en),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .mstatus        (mstatus),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Behavioural csr_file with asynchronous read, plus a write/redirect log.
    word_t     csr_mem [0:4095];
    int        wr_cnt = 0;
    int        rd_cnt = 0;
    int        cyc_cnt = 0;
    csr_addr_t wa_log [0:63];
    word_t     wd_log [0:63];
    int        wc_log [0:63];

    assign csr_rdata = csr_mem[csr_addr];
    assign mstatus   = csr_mem[ISA_CSR_ADDR_MSTATUS];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (csr_write_en) begin
            csr_mem[csr_addr]  <= csr_wdata;
            wa_log[wr_cnt % 64] <= csr_addr;
            wd_log[wr_cnt % 64] <= csr_wdata;
            wc_log[wr_cnt % 64] <= cyc_cnt;
            wr_cnt <= wr_cnt + 1;
        end
        if (redirect_valid) rd_cnt <= rd_cnt + 1;
        assert (!(rst_n && busy && (exc_valid || mret_valid || core_csr_we)))
            else $error("core contract broken: request while busy");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: the architectural CSRs as the spec says they should be.
    word_t m_mstatus, m_mtvec, m_mepc, m_mcause;

    function automatic word_t model_trap_status(input word_t ms);
        word_t mie;
        mie = (ms >> 3) & 1;
        return (ms & ~32'h1888) | (mie << 7) | 32'h1800;
    endfunction

    function automatic word_t model_mret_status(input word_t ms);
        word_t mpie;
        mpie = (ms >> 7) & 1;
        return (ms & ~32'h1888) | (mpie << 3) | 32'h1880;
    endfunction

    task automatic run_req(input bit e, input bit m, input bit i, input bit w, input bit keep_irq,
                           input word_t pc, input word_t cause, input word_t ipc,
                           input csr_addr_t waddr, input word_t wdata);
        int        kind, n_exp, exp_lat, wr0, rd0, c0, cyc, nbusy, n_got;
        csr_addr_t ea [3];
        word_t     ed [3];
        int        ec [3];
        word_t     exp_tgt, t_pc, t_cause;
        kind = e ? 1 : (m ? 2 : ((i && m_mstatus[3]) ? 3 : 0));
        n_exp = 0; exp_lat = 0; exp_tgt = '0; t_pc = '0; t_cause = '0;
        if (kind == 1 || kind == 3) begin
            t_pc    = (kind == 1) ? pc : ipc;
            t_cause = (kind == 1) ? cause : 32'h8000000B;
            ea[0] = ISA_CSR_ADDR_MEPC;    ed[0] = t_pc;    ec[0] = 1;
            ea[1] = ISA_CSR_ADDR_MCAUSE;  ed[1] = t_cause; ec[1] = 2;
            ea[2] = ISA_CSR_ADDR_MSTATUS; ed[2] = model_trap_status(m_mstatus); ec[2] = 3;
            n_exp = 3; exp_lat = 5;
            if ((m_mtvec & 3) == 1 && t_cause >= 32'h80000000)
                exp_tgt = (m_mtvec - 1) + 4 * (t_cause - 32'h80000000);
            else
                exp_tgt = m_mtvec - (m_mtvec & 3);
        end else if (kind == 2) begin
            ea[0] = ISA_CSR_ADDR_MSTATUS; ed[0] = model_mret_status(m_mstatus); ec[0] = 1;
            n_exp = 1; exp_lat = 3;
            exp_tgt = m_mepc & ~32'h3;
        end else if (w) begin
            ea[0] = waddr; ed[0] = wdata; ec[0] = 0;
            n_exp = 1;
        end
        wr0 = wr_cnt; rd0 = rd_cnt; c0 = cyc_cnt;
        exc_valid = e; exc_pc = pc; exc_cause = cause;
        mret_valid = m; irq_ext = i; irq_pc = ipc;
        core_csr_we = w; core_csr_addr = waddr; core_csr_wdata = wdata;
        tick();
        exc_valid = 1'b0; mret_valid = 1'b0; core_csr_we = 1'b0;
        irq_ext = keep_irq ? i : 1'b0;
        if (kind == 0) begin
            check("idle_busy", busy, 0);
        end else begin
            cyc = 1; nbusy = 0;
            while (!redirect_valid && cyc < 12) begin
                if (busy) nbusy++;
                tick();
                cyc++;
            end
            check("latency", cyc, exp_lat);
            check("busy_cycles", nbusy, exp_lat - 1);
            check("redir_pc", redirect_pc, exp_tgt);
            check("busy_at_redir", busy, 0);
            tick();
            check("redir_pulse", redirect_valid, 0);
            check("redir_hold", redirect_pc, exp_tgt);
        end
        n_got = wr_cnt - wr0;
        check("wr_count", n_got, n_exp);
        for (int k = 0; k < n_exp && k < n_got; k++) begin
            check("wr_addr", wa_log[(wr0 + k) % 64], ea[k]);
            check("wr_data", wd_log[(wr0 + k) % 64], ed[k]);
            check("wr_cycle", wc_log[(wr0 + k) % 64], c0 + ec[k]);
        end
        check("redir_count", rd_cnt - rd0, (kind == 0) ? 0 : 1);
        if (kind == 1 || kind == 3) begin
            m_mepc = t_pc; m_mcause = t_cause; m_mstatus = model_trap_status(m_mstatus);
        end else if (kind == 2) begin
            m_mstatus = model_mret_status(m_mstatus);
        end else if (w) begin
            case (waddr)
                ISA_CSR_ADDR_MSTATUS: m_mstatus = wdata;
                ISA_CSR_ADDR_MTVEC:   m_mtvec   = wdata;
                ISA_CSR_ADDR_MEPC:    m_mepc    = wdata;
                ISA_CSR_ADDR_MCAUSE:  m_mcause  = wdata;
                default: ;
            endcase
        end
    endtask

    task automatic wr_csr(input csr_addr_t a, input word_t d);
        run_req(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0, a, d);
    endtask

    task automatic read_csr(input csr_addr_t a, output word_t d);
        core_csr_addr = a;
        #1;
        d = core_csr_rdata;
    endtask

    task automatic check_model();
        word_t d;
        read_csr(ISA_CSR_ADDR_MSTATUS, d); check("mdl_mstatus", d, m_mstatus);
        read_csr(ISA_CSR_ADDR_MTVEC, d);   check("mdl_mtvec", d, m_mtvec);
        read_csr(ISA_CSR_ADDR_MEPC, d);    check("mdl_mepc", d, m_mepc);
        read_csr(ISA_CSR_ADDR_MCAUSE, d);  check("mdl_mcause", d, m_mcause);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t d;
        int    wr0, rd0, nb;
        m_mstatus = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0;

        // Reset: a core write presented during reset must not reach csr_file.
        core_csr_we = 1'b1; core_csr_addr = 12'h340; core_csr_wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_redir_valid", redirect_valid, 0);
        check("rst_redir_pc", redirect_pc, 0);
        check("rst_write_en", csr_write_en, 0);
        core_csr_we = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rst_no_write", wr_cnt, 0);

        wr_csr(ISA_CSR_ADDR_MSTATUS, 32'h8);
        wr_csr(ISA_CSR_ADDR_MTVEC, 32'h100);
        wr_csr(ISA_CSR_ADDR_MEPC, 32'h0);
        wr_csr(ISA_CSR_ADDR_MCAUSE, 32'h0);
        check_model();

        // Exception into direct-mode handler.
        run_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'hB, '0, '0, '0);
        check("exc_target", redirect_pc, 32'h100);
        read_csr(ISA_CSR_ADDR_MSTATUS, d); check("exc_mstatus", d, 32'h1880);
        read_csr(ISA_CSR_ADDR_MEPC, d);    check("exc_mepc", d, 32'h40);
        check_model();

        // Vectored external interrupt.
        wr_csr(ISA_CSR_ADDR_MTVEC, 32'h101);
        wr_csr(ISA_CSR_ADDR_MSTATUS, 32'h8);
        run_req(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 32'h200, '0, '0);
        check("irq_target", redirect_pc, 32'h12C);
        read_csr(ISA_CSR_ADDR_MCAUSE, d); check("irq_mcause", d, 32'h8000000B);
        read_csr(ISA_CSR_ADDR_MEPC, d);   check("irq_mepc", d, 32'h200);

        // Masked interrupt held for 20 cycles.
        wr_csr(ISA_CSR_ADDR_MSTATUS, 32'h0);
        wr0 = wr_cnt; rd0 = rd_cnt; nb = 0;
        irq_ext = 1'b1;
        repeat (20) begin
            tick();
            if (busy) nb++;
        end
        irq_ext = 1'b0;
        check("masked_busy", nb, 0);
        check("masked_writes", wr_cnt - wr0, 0);
        check("masked_redirects", rd_cnt - rd0, 0);

        // mret.
        wr_csr(ISA_CSR_ADDR_MSTATUS, 32'h1880);
        wr_csr(ISA_CSR_ADDR_MEPC, 32'h44);
        run_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        check("mret_target", redirect_pc, 32'h44);
        read_csr(ISA_CSR_ADDR_MSTATUS, d); check("mret_mstatus", d, 32'h1888);

        // Everything at once: exception wins, core write dropped, interrupt stays masked after.
        wr_csr(ISA_CSR_ADDR_MSTATUS, 32'h8);
        wr_csr(ISA_CSR_ADDR_MTVEC, 32'h100);
        run_req(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h2, 32'h300, 12'h340, 32'hDEAD_BEEF);
        check("simul_target", redirect_pc, 32'h100);
        wr0 = wr_cnt; nb = 0;
        repeat (10) begin
            tick();
            if (busy) nb++;
        end
        irq_ext = 1'b0;
        check("simul_no_irq_busy", nb, 0);
        check("simul_no_irq_writes", wr_cnt - wr0, 0);
        check_model();

        // Reset asserted while W_MCAUSE is on the port.
        rd0 = rd_cnt;
        exc_valid = 1'b1; exc_pc = 32'h90; exc_cause = 32'h5;
        tick();
        exc_valid = 1'b0;
        tick();
        check("midrst_pre_busy", busy, 1);
        check("midrst_pre_addr", csr_addr, ISA_CSR_ADDR_MCAUSE);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_write_en", csr_write_en, 0);
        check("midrst_redir_pc", redirect_pc, 0);
        m_mepc = 32'h90;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("midrst_no_redirect", rd_cnt - rd0, 0);
        wr_csr(ISA_CSR_ADDR_MTVEC, 32'h200);
        check_model();

        // Randomized mix of core writes and competing requests.
        for (int it = 0; it < 60; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                case ($urandom_range(0, 3))
                    0: wr_csr(ISA_CSR_ADDR_MSTATUS, $urandom);
                    1: wr_csr(ISA_CSR_ADDR_MTVEC, $urandom);
                    2: wr_csr(ISA_CSR_ADDR_MEPC, $urandom);
                    default: wr_csr(ISA_CSR_ADDR_MCAUSE, $urandom);
                endcase
            end else begin
                run_req($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                        $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, 1'b0,
                        $urandom, $urandom & 32'h7FFF_FFFF, $urandom, 12'h340, $urandom);
            end
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer sitting directly upstream of `csr_file`, owning its single read/write port. In idle it passes the execute stage's Zicsr accesses straight through. On a synchronous exception, an enabled external interrupt or an `mret`, it stalls the core and serialises the required CSR updates through the one write port. It then issues a one-cycle PC redirect to the trap handler or to the return address.

## Interface
No parameters; widths come from `word_t` (32) and `csr_addr_t` (12).

One clock; reset is asynchronous and active-low.

- `clk`  in  1  core clock
- `rst_n`  in  1  async active-low reset
- `exc_valid`  in  1  synchronous exception pulse from execute
- `exc_cause`  in  32  mcause value for the exception (bit 31 = 0)
- `exc_pc`  in  32  PC of the faulting instruction
- `mret_valid`  in  1  mret retiring pulse
- `irq_ext`  in  1  machine external interrupt, level
- `irq_pc`  in  32  PC of the next unexecuted instruction
- `core_csr_we`  in  1  Zicsr write enable from execute
- `core_csr_addr`  in  12  Zicsr address
- `core_csr_wdata`  in  32  Zicsr write data
- `core_csr_rdata`  out  32  equals `csr_rdata`, combinational
- `csr_write_en`  out  1  to `csr_file`
- `csr_addr`  out  12  to `csr_file`
- `csr_wdata`  out  32  to `csr_file`
- `csr_rdata`  in  32  from `csr_file` dout
- `mstatus`  in  32  live mstatus from `csr_file`
- `busy`  out  1  stall request to the core
- `redirect_valid`  out  1  one-cycle PC redirect strobe
- `redirect_pc`  out  32  redirect target

## Operation
- **States:** IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, R_MTVEC, M_STATUS, M_EPC.
- **IDLE pass-through:**
  - csr port = core port.
  - `core_csr_we` is suppressed (write_en = 0) in any cycle where a trap or mret is accepted.
- **Acceptance:** sampled only in IDLE. Priority is exception > mret > interrupt.
  - Interrupt is taken iff `irq_ext && mstatus[3]`.
  - A losing mret is discarded. A losing interrupt stays pending (level).
  - The accept edge latches pc and cause.
    - Exception: `exc_pc`, `exc_cause`.
    - Interrupt: `irq_pc`, 0x8000000B.
- **Trap sequence:**
  - **W_MEPC:** write MEPC = pc.
  - **W_MCAUSE:** write MCAUSE = cause.
  - **W_MSTATUS:** write mstatus with MPIE(7) ← MIE(3), MIE ← 0, MPP(12:11) ← 2'b11; other bits kept.
  - **R_MTVEC:** addr MTVEC, no write. The target is registered from `csr_rdata`:
    - base = {rdata[31:2], 2'b00};
    - if rdata[1:0] == 1 and cause is an interrupt, target = base + 4·cause[30:0];
    - otherwise target = base.
- **mret sequence:**
  - **M_STATUS:** write mstatus with MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
  - **M_EPC:** addr MEPC, no write; target = {rdata[31:2], 2'b00}.
- **Address outputs:** `csr_addr` in non-IDLE states is the state's CSR address; `csr_wdata` is 0 in read states.
- **Protocol:** requests and core CSR writes arriving while `busy` = 1 are ignored; core contract, asserted in the bench.

## Timing
- **Reset:** `rst_n` low forces IDLE immediately, with `busy`=0, `redirect_valid`=0, `redirect_pc`=0, `csr_write_en`=0.
  - Reset mid-sequence aborts it; already-written CSRs are not rolled back.
- **busy:** combinational (state != IDLE). It is high from the cycle after the accept edge.
- **Trap timeline:** accept edge ends cycle 0. Cycles 1–4 are W_MEPC, W_MCAUSE, W_MSTATUS, R_MTVEC with `busy`=1. Cycle 5 is IDLE with `redirect_valid`=1 and `busy`=0.
- **mret timeline:** cycles 1–2 are M_STATUS, M_EPC. Cycle 3 has `redirect_valid`=1.
- **Redirect outputs:** `redirect_valid` is registered and high exactly one cycle. `redirect_pc` holds its value until the next redirect.
- **Back-to-back:** a new request may be accepted in the redirect cycle. An interrupt is only taken then if mstatus.MIE is set.

## Structure
- Shared `types.sv` package gains:
  - `ISA_MSTATUS_MIE`=3, `ISA_MSTATUS_MPIE`=7, `ISA_MSTATUS_MPP_LO`=11;
  - `ISA_MCAUSE_MEI`=32'h8000000B;
  - `trap_state_t` enum.
- It already provides `word_t`, `csr_addr_t` and the `ISA_CSR_ADDR_*` constants.
- Single FSM module; no sub-module is warranted.

## Test plan
- **Exception:**
  - Setup: mtvec=0x100, mstatus=0x8; exc_valid with pc 0x40, cause 0xB.
  - Expect: writes MEPC=0x40, MCAUSE=0xB, mstatus=0x1880 in cycles 1–3; redirect 0x100 in cycle 5.
- **Vectored interrupt:**
  - Setup: mtvec=0x101, mstatus=0x8; irq_ext=1, irq_pc=0x200.
  - Expect: MEPC=0x200, MCAUSE=0x8000000B; redirect 0x12C.
- **Masked interrupt:**
  - Setup: mstatus=0, irq_ext=1 for 20 cycles.
  - Expect: busy stays 0, no writes, no redirect.
- **mret:**
  - Setup: mstatus=0x1880, mepc=0x44; mret_valid.
  - Expect: mstatus write 0x1888 in cycle 1; redirect 0x44 in cycle 3.
- **Simultaneous requests:**
  - Setup: exc_valid, mret_valid, irq_ext and core_csr_we in the same IDLE cycle, with mstatus=0x8.
  - Expect: core write suppressed; only the exception sequence runs; after the redirect, no interrupt is taken (MIE=0).
- **Reset mid-sequence:**
  - Setup: rst_n low during W_MCAUSE.
  - Expect: busy and csr_write_en drop in the same cycle; no redirect; after release, pass-through works.
